comb_sweep_ctrl: RTL
====================

# comb_sweep_ctrl

Self-checking sweep controller for the 4-input combinational test block, whose outputs are `str`, `dataflow`, `behavior` and `prim`. It sits on both sides of that block:
- Upstream, it drives the input vector `{pd,pc,pb,pa}` through an exhaustive registered sweep.
- Downstream, it samples the four implementation outputs after a programmable settle time, checks them against each other, and reports an error count, the first failing vector, and a pass/fail summary.

## Interface
Parameters:
- `SETTLE`, default 1: cycles each vector is held before sampling; legal range 1..15.
- `NUM_VEC`, default 16: number of vectors swept, 0..NUM_VEC-1; legal range 1..16.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `abort`  in  1  synchronous cancel of a running sweep.
- `res_str`  in  1  structural implementation output; this is the golden reference.
- `res_dataflow`, `res_behavior`, `res_prim`  in  1 each  outputs under check.
- `pa`, `pb`, `pc`, `pd`  out  1 each  registered stimulus; `{pd,pc,pb,pa}` = current vector, `pa` is the LSB.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `pass`  out  1  1 when the last completed sweep had zero errors.
- `err_cnt`  out  5  number of failing vectors, 0..16.
- `first_fail_vec`  out  4  lowest failing vector.
- `first_fail_mask`  out  3  mismatch mask at `first_fail_vec`, bit order `{prim,behavior,dataflow}`.

## Operation
The controller has two states.

IDLE:
- `busy`=0 and vec=0.
- `start`=1 with `abort`=0 → WAIT. On that same edge:
  - vec←0 and settle counter←0.
  - `err_cnt`, `first_fail_vec`, `first_fail_mask`, `pass` and fail_seen are cleared.
- If `start` and `abort` are both 1, abort wins and the controller stays in IDLE.

WAIT:
- `busy`=1. The settle counter increments each cycle.
- When counter==SETTLE-1 the edge is a sample edge:
  - mask = `{res_prim^res_str, res_behavior^res_str, res_dataflow^res_str}`.
  - If mask≠0: `err_cnt`+1. If fail_seen=0, also latch `first_fail_vec`=vec, `first_fail_mask`=mask, and set fail_seen.
  - If vec==NUM_VEC-1 → IDLE. On that edge `done`←1, `pass`←(final err_cnt==0), vec←0.
  - Otherwise vec+1 and counter←0.
- `abort`=1 → IDLE at that edge:
  - vec←0.
  - No `done` pulse; `pass` stays 0.
  - `err_cnt` and first-fail fields keep their partial values.
- `start` is ignored while `busy`=1.

Result holding and width rules:
- `err_cnt`, `pass` and the first-fail fields hold until the next accepted `start`.
- `err_cnt` is 5 bits and cannot overflow, since at most 16 vectors are checked.
- The vector does not wrap inside a sweep.
- Only the sample edge counts: mismatches in non-sample cycles are never recorded.

## Timing
- Reset values:
  - `pa`..`pd`=0, `busy`=0, `done`=0, `pass`=0.
  - `err_cnt`=0, `first_fail_vec`=0, `first_fail_mask`=0.
  - Internal state: state=IDLE, counter=0, fail_seen=0.
- Reset asserted mid-sweep forces all of the above immediately, without waiting for a clock edge.
- Counting from the start edge E0:
  - Vector k is driven from edge E0+k·SETTLE.
  - Vector k is sampled at edge E0+(k+1)·SETTLE.
- The final sample edge is E0+NUM_VEC·SETTLE. At that edge:
  - `busy` falls.
  - `done` is high for exactly the following cycle.
  - `pass` is valid from the same cycle.
- A new `start` is accepted in the cycle `done` is high, since the controller is already in IDLE.

## Structure
- Package `comb_sweep_pkg` holds:
  - the state enum (IDLE, WAIT);
  - `VEC_W`=4, `CNT_W`=5 and `MASK_W`=3.
- One combinational sub-module, `comb_sweep_cmp`, takes the four result bits and produces the 3-bit mask and a mismatch flag.
- The FSM, counters and result registers stay in `comb_sweep_ctrl`.

## Test plan
- **All results tied to one function, SETTLE=1, NUM_VEC=16, start at E0:**
  - `{pd,pc,pb,pa}` steps 0..15, one per cycle.
  - `busy` is 1 from E0 to E0+16.
  - `done` pulses after E0+16; `pass`=1 and `err_cnt`=0.
- **`res_prim` inverted only at vectors 5 and 9:**
  - `err_cnt`=2, `first_fail_vec`=5, `first_fail_mask`=3'b100, `pass`=0.
- **SETTLE=3, `res_dataflow` wrong only in the first 2 cycles of every vector:**
  - `err_cnt`=0 and `pass`=1.
  - `done` pulses after E0+48.
- **`abort` during vector 7 (SETTLE=1):**
  - `busy`=0 and vec=0 next edge; no `done`; `pass`=0.
  - Partial `err_cnt` is held.
  - A following `start` clears the results and restarts at vector 0.
- **`start` held high during the sweep:** the sweep is not restarted. **`start` and `abort` together in IDLE:** the controller stays in IDLE.
- **`rst_n` pulled low asynchronously at vector 10:** all outputs become 0 before the next `clk` edge.
- **`NUM_VEC`=1 corner:** `done` pulses after E0+SETTLE.

Source files
------------

// File: rtl/comb_sweep_pkg.sv
// Shared types and widths for the combinational-block sweep controller.
package comb_sweep_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int VEC_W  = 4;
  localparam int CNT_W  = 5;
  localparam int MASK_W = 3;
  // Settle counter width: SETTLE is at most 15, so the counter reaches at most 14.
  localparam int SET_W  = 4;

endpackage

// File: rtl/comb_sweep_cmp.sv
// Compares the three implementations under check against the structural reference.
module comb_sweep_cmp
  import comb_sweep_pkg::*;
(
  input  logic              res_str_i,
  input  logic              res_dataflow_i,
  input  logic              res_behavior_i,
  input  logic              res_prim_i,
  output logic [MASK_W-1:0] mask_o,
  output logic              mismatch_o
);

  assign mask_o     = {res_prim_i ^ res_str_i, res_behavior_i ^ res_str_i, res_dataflow_i ^ res_str_i};
  assign mismatch_o = |mask_o;

endmodule

// File: rtl/comb_sweep_ctrl.sv
// Exhaustive registered sweep of a 4-input combinational block with cross-checking
// of its four implementations, error counting and first-failure capture.
module comb_sweep_ctrl
  import comb_sweep_pkg::*;
#(
  parameter int SETTLE  = 1,
  parameter int NUM_VEC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              res_str,
  input  logic              res_dataflow,
  input  logic              res_behavior,
  input  logic              res_prim,
  output logic              pa,
  output logic              pb,
  output logic              pc,
  output logic              pd,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [VEC_W-1:0]  first_fail_vec,
  output logic [MASK_W-1:0] first_fail_mask
);

  localparam logic [SET_W-1:0] LAST_CNT = SET_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

  state_e              state_q;
  logic [VEC_W-1:0]    vec_q;
  logic [SET_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    err_q;
  logic [CNT_W-1:0]    err_d;
  logic [VEC_W-1:0]    ffv_q;
  logic [MASK_W-1:0]   ffm_q;
  logic                fail_seen_q;
  logic                pass_q;
  logic                done_q;
  logic [MASK_W-1:0]   mask;
  logic                mismatch;

  comb_sweep_cmp u_cmp (
    .res_str_i      (res_str),
    .res_dataflow_i (res_dataflow),
    .res_behavior_i (res_behavior),
    .res_prim_i     (res_prim),
    .mask_o         (mask),
    .mismatch_o     (mismatch)
  );

  // Error count as it stands after this edge; also feeds the final pass verdict.
  assign err_d = err_q + CNT_W'(mismatch);

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values; the async reset clears everything without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      cnt_q       <= '0;
      err_q       <= '0;
      ffv_q       <= '0;
      ffm_q       <= '0;
      fail_seen_q <= 1'b0;
      pass_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q     <= WAIT;
            vec_q       <= '0;
            cnt_q       <= '0;
            err_q       <= '0;
            ffv_q       <= '0;
            ffm_q       <= '0;
            fail_seen_q <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        WAIT: begin
          if (abort) begin
            // Partial results are kept for inspection; no done, pass stays low.
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
          end else if (cnt_q == LAST_CNT) begin
            cnt_q <= '0;
            if (mismatch) begin
              err_q <= err_d;
              if (!fail_seen_q) begin
                ffv_q       <= vec_q;
                ffm_q       <= mask;
                fail_seen_q <= 1'b1;
              end
            end
            if (vec_q == LAST_VEC) begin
              state_q <= IDLE;
              vec_q   <= '0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              vec_q <= vec_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {pd, pc, pb, pa}  = vec_q;
  assign busy            = (state_q == WAIT);
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_q;
  assign first_fail_vec  = ffv_q;
  assign first_fail_mask = ffm_q;

endmodule
